fft_magnitude_sq: RTL and testbench

//  Upstream neighbour of the fundamental-bin finder. Converts the complex FFT output stream into a

---
 rtl/fft_mag_pkg.sv | 14 +
 rtl/axis_if.sv | 12 +
 rtl/fft_mag_sq_pipe.sv | 124 ++++++++++++
 rtl/fft_magnitude_sq.sv | 141 ++++++++++++++
 tb/tb_fft_magnitude_sq.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_mag_pkg.sv
// Shared constants and types for the FFT squared-magnitude stage.
package fft_mag_pkg;

    localparam int FFT_N = 1024;
    localparam int IW    = 24;
    localparam int BIN_W = $clog2(FFT_N);

    typedef logic signed [IW-1:0] cplx_comp_t;
    typedef logic [2*IW-1:0]      mag_t;
    typedef logic [BIN_W-1:0]     bin_t;

    localparam bin_t LAST_BIN = bin_t'(FFT_N - 1);

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-stream style bundle. A beat transfers on a clock edge where valid && ready;
// the master holds valid and data steady until that edge, and ready may depend on valid.
interface Axis_If #(
    parameter int W = 48
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport Master (output valid, output data, input ready);
    modport Slave  (input valid, input data, output ready);
endinterface

// File: rtl/fft_mag_sq_pipe.sv
// Three-stage re^2 + im^2 datapath with a shared stall; bin index and error flag ride along
// with each beat so they emerge aligned with its magnitude.
import fft_mag_pkg::*;

module fft_mag_sq_pipe (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  cplx_comp_t in_re,
    input  cplx_comp_t in_im,
    input  bin_t       in_bin,
    input  logic       in_err,
    output logic       out_valid,
    input  logic       out_ready,
    output mag_t       out_mag,
    output bin_t       out_bin,
    output logic       out_err
);

    logic       advance;

    logic       s1_valid_q, s1_valid_d;
    cplx_comp_t s1_re_q, s1_re_d;
    cplx_comp_t s1_im_q, s1_im_d;
    bin_t       s1_bin_q, s1_bin_d;
    logic       s1_err_q, s1_err_d;

    logic       s2_valid_q, s2_valid_d;
    mag_t       s2_re_sq_q, s2_re_sq_d;
    mag_t       s2_im_sq_q, s2_im_sq_d;
    bin_t       s2_bin_q, s2_bin_d;
    logic       s2_err_q, s2_err_d;

    logic       s3_valid_q, s3_valid_d;
    mag_t       s3_mag_q, s3_mag_d;
    bin_t       s3_bin_q, s3_bin_d;
    logic       s3_err_q, s3_err_d;

    logic signed [2*IW-1:0] re_ext, im_ext, re_sq, im_sq;

    // Whole pipe moves together: it only stalls when the output beat is held by the sink.
    assign advance  = !s3_valid_q || out_ready;
    assign in_ready = advance;

    // Squares are non-negative and at most 2^(2IW-2), so the sum below cannot overflow 2IW bits.
    assign re_ext = {{IW{s1_re_q[IW-1]}}, s1_re_q};
    assign im_ext = {{IW{s1_im_q[IW-1]}}, s1_im_q};
    assign re_sq  = re_ext * re_ext;
    assign im_sq  = im_ext * im_ext;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_re_d    = s1_re_q;
        s1_im_d    = s1_im_q;
        s1_bin_d   = s1_bin_q;
        s1_err_d   = s1_err_q;
        s2_valid_d = s2_valid_q;
        s2_re_sq_d = s2_re_sq_q;
        s2_im_sq_d = s2_im_sq_q;
        s2_bin_d   = s2_bin_q;
        s2_err_d   = s2_err_q;
        s3_valid_d = s3_valid_q;
        s3_mag_d   = s3_mag_q;
        s3_bin_d   = s3_bin_q;
        s3_err_d   = s3_err_q;
        if (advance) begin
            s1_valid_d = in_valid;
            s1_re_d    = in_re;
            s1_im_d    = in_im;
            s1_bin_d   = in_bin;
            s1_err_d   = in_err;
            s2_valid_d = s1_valid_q;
            s2_re_sq_d = mag_t'(re_sq);
            s2_im_sq_d = mag_t'(im_sq);
            s2_bin_d   = s1_bin_q;
            s2_err_d   = s1_err_q;
            s3_valid_d = s2_valid_q;
            s3_mag_d   = s2_re_sq_q + s2_im_sq_q;
            s3_bin_d   = s2_bin_q;
            s3_err_d   = s2_err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_re_q    <= '0;
            s1_im_q    <= '0;
            s1_bin_q   <= '0;
            s1_err_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_re_sq_q <= '0;
            s2_im_sq_q <= '0;
            s2_bin_q   <= '0;
            s2_err_q   <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_mag_q   <= '0;
            s3_bin_q   <= '0;
            s3_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_re_q    <= s1_re_d;
            s1_im_q    <= s1_im_d;
            s1_bin_q   <= s1_bin_d;
            s1_err_q   <= s1_err_d;
            s2_valid_q <= s2_valid_d;
            s2_re_sq_q <= s2_re_sq_d;
            s2_im_sq_q <= s2_im_sq_d;
            s2_bin_q   <= s2_bin_d;
            s2_err_q   <= s2_err_d;
            s3_valid_q <= s3_valid_d;
            s3_mag_q   <= s3_mag_d;
            s3_bin_q   <= s3_bin_d;
            s3_err_q   <= s3_err_d;
        end
    end

    assign out_valid = s3_valid_q;
    assign out_mag   = s3_mag_q;
    assign out_bin   = s3_bin_q;
    assign out_err   = s3_err_q;

endmodule

// File: rtl/fft_magnitude_sq.sv
// Complex FFT stream to squared-magnitude stream with bin numbering and tlast checking.
// Optional FFT_MAG_PEAK_EN adds a per-frame peak (max magnitude, lowest bin on ties) report.
import fft_mag_pkg::*;

module fft_magnitude_sq (
    input  logic   clk,
    input  logic   reset,
    Axis_If.Slave  fft_in,
    input  logic   fft_in_last,
    Axis_If.Master mag,
    output logic   mag_last,
    output bin_t   mag_bin,
    output logic   frame_err
`ifdef FFT_MAG_PEAK_EN
    ,
    output mag_t   peak_mag,
    output bin_t   peak_bin,
    output logic   peak_valid
`endif
);

    bin_t       bin_cnt_q, bin_cnt_d;
    logic       accept;
    logic       at_end;
    logic       in_err;
    cplx_comp_t in_re, in_im;
    logic       pipe_in_ready;
    logic       pipe_out_valid;
    mag_t       pipe_out_mag;
    bin_t       pipe_out_bin;
    logic       pipe_out_err;

    assign in_re  = fft_in.data[IW-1:0];
    assign in_im  = fft_in.data[2*IW-1:IW];
    assign accept = fft_in.valid && pipe_in_ready;
    assign at_end = (bin_cnt_q == LAST_BIN);
    // Any disagreement between the core's tlast and our count is an error; either way we restart at 0.
    assign in_err = (fft_in_last != at_end);

    always_comb begin
        bin_cnt_d = bin_cnt_q;
        if (accept) begin
            if (fft_in_last || at_end) begin
                bin_cnt_d = '0;
            end else begin
                bin_cnt_d = bin_cnt_q + bin_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_cnt_q <= '0;
        end else begin
            bin_cnt_q <= bin_cnt_d;
        end
    end

    fft_mag_sq_pipe u_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (fft_in.valid),
        .in_ready  (pipe_in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .in_bin    (bin_cnt_q),
        .in_err    (in_err),
        .out_valid (pipe_out_valid),
        .out_ready (mag.ready),
        .out_mag   (pipe_out_mag),
        .out_bin   (pipe_out_bin),
        .out_err   (pipe_out_err)
    );

    assign fft_in.ready = pipe_in_ready;
    assign mag.valid    = pipe_out_valid;
    assign mag.data     = pipe_out_mag;
    assign mag_bin      = pipe_out_bin;
    assign mag_last     = (pipe_out_bin == LAST_BIN);
    assign frame_err    = pipe_out_valid && mag.ready && pipe_out_err;

`ifdef FFT_MAG_PEAK_EN
    logic mag_hs;
    mag_t run_max_q, run_max_d;
    bin_t run_bin_q, run_bin_d;
    mag_t peak_mag_q, peak_mag_d;
    bin_t peak_bin_q, peak_bin_d;
    logic peak_valid_q, peak_valid_d;
    mag_t base_max, cand_max;
    bin_t base_bin, cand_bin;

    assign mag_hs = pipe_out_valid && mag.ready;

    // Bin 0 starts a new frame, so the running max is compared against zero there.
    always_comb begin
        base_max     = (pipe_out_bin == '0) ? '0 : run_max_q;
        base_bin     = (pipe_out_bin == '0) ? '0 : run_bin_q;
        cand_max     = base_max;
        cand_bin     = base_bin;
        if ((pipe_out_bin == '0) || (pipe_out_mag > base_max)) begin
            cand_max = pipe_out_mag;
            cand_bin = pipe_out_bin;
        end
        run_max_d    = run_max_q;
        run_bin_d    = run_bin_q;
        peak_mag_d   = peak_mag_q;
        peak_bin_d   = peak_bin_q;
        peak_valid_d = 1'b0;
        if (mag_hs) begin
            run_max_d = cand_max;
            run_bin_d = cand_bin;
            if (mag_last) begin
                peak_mag_d   = cand_max;
                peak_bin_d   = cand_bin;
                peak_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_max_q    <= '0;
            run_bin_q    <= '0;
            peak_mag_q   <= '0;
            peak_bin_q   <= '0;
            peak_valid_q <= 1'b0;
        end else begin
            run_max_q    <= run_max_d;
            run_bin_q    <= run_bin_d;
            peak_mag_q   <= peak_mag_d;
            peak_bin_q   <= peak_bin_d;
            peak_valid_q <= peak_valid_d;
        end
    end

    assign peak_mag   = peak_mag_q;
    assign peak_bin   = peak_bin_q;
    assign peak_valid = peak_valid_q;
`endif

endmodule

// File: tb/tb_fft_magnitude_sq.sv
// Scoreboard bench for fft_magnitude_sq: directed frames, stalls, framing errors, reset.
import fft_mag_pkg::*;

module tb_fft_magnitude_sq;

    localparam int EW = 2*IW + BIN_W + 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic fft_in_last;
    logic mag_last;
    bin_t mag_bin;
    logic frame_err;
`ifdef FFT_MAG_PEAK_EN
    mag_t peak_mag;
    bin_t peak_bin;
    logic peak_valid;
`endif

    Axis_If #(.W(2*IW)) fft_in ();
    Axis_If #(.W(2*IW)) mag ();

    fft_magnitude_sq dut (
        .clk         (clk),
        .reset       (reset),
        .fft_in      (fft_in),
        .fft_in_last (fft_in_last),
        .mag         (mag),
        .mag_last    (mag_last),
        .mag_bin     (mag_bin),
        .frame_err   (frame_err)
`ifdef FFT_MAG_PEAK_EN
        ,
        .peak_mag    (peak_mag),
        .peak_bin    (peak_bin),
        .peak_valid  (peak_valid)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;
    logic [EW-1:0] exp_q[$];
    int acc_q[$];
    bit lat_chk = 1'b0;
    bit rdy_rand = 1'b0;
    bit peak_chk = 1'b0;
    int peak_pulses = 0;
    bin_t model_cnt = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Driver: present one beat and hold it until accepted, then log its expected response.
    task automatic send(input int re, input int im, input logic last, input logic [47:0] exp_mag);
        logic at_end;
        logic err;
        int budget;
        @(posedge clk);
        #1;
        fft_in.valid = 1'b1;
        fft_in.data  = {im[IW-1:0], re[IW-1:0]};
        fft_in_last  = last;
        budget = 0;
        @(negedge clk);
        while (!fft_in.ready) begin
            budget++;
            if (budget > 100) begin
                check("accept_timeout", 64'd0, 64'd1);
                return;
            end
            @(negedge clk);
        end
        at_end = (model_cnt == bin_t'(FFT_N - 1));
        err    = (last != at_end);
        exp_q.push_back({err, at_end, model_cnt, exp_mag});
        acc_q.push_back(cyc);
        model_cnt = (last || at_end) ? bin_t'(0) : model_cnt + bin_t'(1);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        fft_in.valid = 1'b0;
        fft_in_last  = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 500) begin
            @(negedge clk);
            b++;
        end
        repeat (2) @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        fft_in.valid = 1'b0;
        fft_in_last  = 1'b0;
        exp_q.delete();
        acc_q.delete();
        model_cnt = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_valid", 64'(mag.valid), 64'd0);
        check("post_reset_bin", 64'(mag_bin), 64'd0);
    endtask

    // Sink ready: always high, or a fresh coin flip each cycle while stalls are being exercised.
    initial begin
        mag.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            mag.ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compares every completed output beat against the head of the expected queue.
    initial begin
        logic [EW-1:0] e;
        int a;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("in_ready", 64'(fft_in.ready), 64'(!mag.valid || mag.ready));
                if (mag.valid && mag.ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        a = acc_q.pop_front();
                        check("mag", 64'(mag.data), 64'(e[2*IW-1:0]));
                        check("mag_bin", 64'(mag_bin), 64'(e[2*IW+BIN_W-1:2*IW]));
                        check("mag_last", 64'(mag_last), 64'(e[2*IW+BIN_W]));
                        check("frame_err", 64'(frame_err), 64'(e[EW-1]));
                        if (lat_chk) check("latency", 64'(cyc - a), 64'd3);
                    end
                end else begin
                    check("frame_err_idle", 64'(frame_err), 64'd0);
                end
`ifdef FFT_MAG_PEAK_EN
                if (peak_chk && peak_valid) begin
                    peak_pulses++;
                    check("peak_bin", 64'(peak_bin), 64'd7);
                    check("peak_mag", 64'(peak_mag), 64'h1000);
                end
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fft_in.valid = 1'b0;
        fft_in.data  = '0;
        fft_in_last  = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mag_valid", 64'(mag.valid), 64'd0);
        check("rst_mag_last", 64'(mag_last), 64'd0);
        check("rst_mag_bin", 64'(mag_bin), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
`ifdef FFT_MAG_PEAK_EN
        check("rst_peak_valid", 64'(peak_valid), 64'd0);
        check("rst_peak_mag", 64'(peak_mag), 64'd0);
        check("rst_peak_bin", 64'(peak_bin), 64'd0);
`endif

        // Full frame, re = bin, im = 0, no stalls.
        lat_chk = 1'b1;
        for (int b = 0; b < FFT_N; b++) send(b, 0, b == FFT_N - 1, 48'(b * b));
        idle();
        drain();

        // Extreme operands.
        send(-(1 << 23), -(1 << 23), 1'b0, 48'h800000000000);
        send((1 << 23) - 1, 0, 1'b0, 48'h3FFFFF000001);
        idle();
        drain();
        do_reset();

        // Same frame under random back-pressure.
        lat_chk = 1'b0;
        rdy_rand = 1'b1;
        for (int b = 0; b < FFT_N; b++) send(b, 0, b == FFT_N - 1, 48'(b * b));
        idle();
        drain();
        rdy_rand = 1'b0;

        // Early tlast at bin 500, then a frame missing its tlast, then one more beat.
        lat_chk = 1'b1;
        for (int b = 0; b <= 500; b++) send(b, 0, b == 500, 48'(b * b));
        for (int b = 0; b < FFT_N; b++) send(b, 1, 1'b0, 48'(b * b + 1));
        send(3, 4, 1'b0, 48'd25);
        idle();
        drain();

        // Reset in the middle of a frame.
        for (int b = 0; b < 300; b++) send(b, 0, 1'b0, 48'(b * b));
        do_reset();
        send(5, 0, 1'b0, 48'd25);
        idle();
        drain();

`ifdef FFT_MAG_PEAK_EN
        // Peak of 0x1000 tied at bins 7 and 9; every other bin is 1.
        do_reset();
        peak_pulses = 0;
        peak_chk = 1'b1;
        for (int b = 0; b < FFT_N; b++) begin
            if (b == 7) send(64, 0, 1'b0, 48'h1000);
            else if (b == 9) send(-64, 0, 1'b0, 48'h1000);
            else send(1, 0, b == FFT_N - 1, 48'd1);
        end
        idle();
        drain();
        repeat (3) @(negedge clk);
        check("peak_pulses", 64'(peak_pulses), 64'd1);
        peak_chk = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
